transmission_estimator: RTL and testbench

//  Downstream neighbour of ale_top in the haze-removal pipeline. Latches the atmospheric light A
//  (a_r/g/b, inv_a_r/g/b) on ale_valid, then streams one frame of RGB pixels. Per pixel it produces

---
 rtl/transmission_estimator_if.sv | 37 +++
 rtl/transmission_estimator.sv | 215 +++++++++++++++++++++
 tb/tb_transmission_estimator.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transmission_estimator_if.sv
// Bus bundle between ale_top/pixel source and transmission_estimator.
interface transmission_estimator_if;
    // Atmospheric light and its reciprocals from ale_top
    logic [7:0]  a_r;
    logic [7:0]  a_g;
    logic [7:0]  a_b;
    logic [15:0] inv_a_r;
    logic [15:0] inv_a_g;
    logic [15:0] inv_a_b;
    logic        ale_valid;

    // Pixel stream in
    logic [23:0] input_pixel;
    logic        input_is_valid;

    // Transmission stream out
    logic [23:0] out_pixel;
    logic [7:0]  out_t;
    logic [23:0] out_a;
    logic        output_is_valid;
    logic        busy;
    logic        drop_err;

    // Source side: drives A and pixels, observes results
    modport master (
        output a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, ale_valid,
        output input_pixel, input_is_valid,
        input  out_pixel, out_t, out_a, output_is_valid, busy, drop_err
    );

    // Estimator side
    modport slave (
        input  a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, ale_valid,
        input  input_pixel, input_is_valid,
        output out_pixel, out_t, out_a, output_is_valid, busy, drop_err
    );
endinterface

// File: rtl/transmission_estimator.sv
// Per-pixel haze transmission estimate t = 1 - OMEGA*min_c(I_c/A_c), Q0.8,
// clamped to T_MIN, with the source pixel delay-matched alongside.
module transmission_estimator #(
    parameter int unsigned FRAME_PIXELS = 262144,
    parameter int unsigned OMEGA        = 243,
    parameter int unsigned T_MIN        = 26
) (
    input logic                     clk,
    input logic                     rst,
    transmission_estimator_if.slave bus
);

    localparam int unsigned CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [7:0] OMEGA_Q = 8'(OMEGA);
    localparam logic [7:0] T_MIN_Q = 8'(T_MIN);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    // Latched atmospheric light for the current frame
    logic [23:0] a_q;
    logic [15:0] inv_r_q;
    logic [15:0] inv_g_q;
    logic [15:0] inv_b_q;

    // FSM decode
    logic latch_a;
    logic clr_cnt;
    logic inc_cnt;
    logic accept;
    logic drop;

    // Pipeline registers
    logic        v1_q, v2_q, v3_q, v4_q;
    logic [23:0] pix1_q, pix2_q, pix3_q, pix4_q;
    logic [23:0] prod_r1_q, prod_g1_q, prod_b1_q;
    logic [7:0]  n_r2_q, n_g2_q, n_b2_q;
    logic [7:0]  m3_q;
    logic [7:0]  t4_q;
    logic        busy_q;
    logic        drop_q;

    // S4 combinational transmission
    logic [7:0] k_s4;
    logic [7:0] t_raw_s4;
    logic [7:0] t_s4;

    // Scale back from Q8.8 ratio to 8 bits, saturating above 1.0
    function automatic logic [7:0] sat8(input logic [23:0] p);
        return (p[23:16] != 8'd0) ? 8'hFF : p[15:8];
    endfunction

    function automatic logic [7:0] min3(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] z);
        logic [7:0] xy;
        xy = (x < y) ? x : y;
        return (xy < z) ? xy : z;
    endfunction

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        latch_a = 1'b0;
        clr_cnt = 1'b0;
        inc_cnt = 1'b0;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                drop = bus.input_is_valid;
                if (bus.ale_valid) begin
                    latch_a = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.input_is_valid) begin
                    accept = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        // Frame end: a fresh A here chains straight into the next frame
                        clr_cnt = 1'b1;
                        if (bus.ale_valid) begin
                            latch_a = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        inc_cnt = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, latched A and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            inv_r_q <= '0;
            inv_g_q <= '0;
            inv_b_q <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr_cnt) begin
                cnt_q <= '0;
            end else if (inc_cnt) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (latch_a) begin
                a_q     <= {bus.a_r, bus.a_g, bus.a_b};
                inv_r_q <= bus.inv_a_r;
                inv_g_q <= bus.inv_a_g;
                inv_b_q <= bus.inv_a_b;
            end
            busy_q <= (state_d == RUN);
            drop_q <= drop_q | drop;
        end
    end

    // S1: multiply by reciprocal; A is baked into the products from here on
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            pix1_q    <= '0;
            prod_r1_q <= '0;
            prod_g1_q <= '0;
            prod_b1_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                pix1_q    <= bus.input_pixel;
                prod_r1_q <= 24'(bus.input_pixel[23:16]) * 24'(inv_r_q);
                prod_g1_q <= 24'(bus.input_pixel[15:8])  * 24'(inv_g_q);
                prod_b1_q <= 24'(bus.input_pixel[7:0])   * 24'(inv_b_q);
            end
        end
    end

    // S2: normalise ratios to 8 bits with saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            pix2_q <= '0;
            n_r2_q <= '0;
            n_g2_q <= '0;
            n_b2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pix2_q <= pix1_q;
                n_r2_q <= sat8(prod_r1_q);
                n_g2_q <= sat8(prod_g1_q);
                n_b2_q <= sat8(prod_b1_q);
            end
        end
    end

    // S3: dark channel of the normalised pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            pix3_q <= '0;
            m3_q   <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                pix3_q <= pix2_q;
                m3_q   <= min3(n_r2_q, n_g2_q, n_b2_q);
            end
        end
    end

    // S4 arithmetic: t = 255 - (OMEGA*m >> 8), clamped from below
    always_comb begin
        k_s4     = 8'((16'(OMEGA_Q) * 16'(m3_q)) >> 8);
        t_raw_s4 = 8'hFF - k_s4;
        t_s4     = (t_raw_s4 < T_MIN_Q) ? T_MIN_Q : t_raw_s4;
    end

    // S4: output registers, holding their value between valid pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            v4_q   <= 1'b0;
            pix4_q <= '0;
            t4_q   <= '0;
        end else begin
            v4_q <= v3_q;
            if (v3_q) begin
                pix4_q <= pix3_q;
                t4_q   <= t_s4;
            end
        end
    end

    assign bus.out_pixel       = pix4_q;
    assign bus.out_t           = t4_q;
    assign bus.out_a           = a_q;
    assign bus.output_is_valid = v4_q;
    assign bus.busy            = busy_q;
    assign bus.drop_err        = drop_q;

endmodule

// File: tb/tb_transmission_estimator.sv
// Scoreboard bench for transmission_estimator with a 4-pixel frame.
module tb_transmission_estimator;

    localparam int unsigned FP = 4;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  t;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    transmission_estimator_if bus ();

    transmission_estimator #(
        .FRAME_PIXELS(FP),
        .OMEGA(243),
        .T_MIN(26)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nvalid = 0;
    exp_t sb[$];

    // Reference reciprocals for the A currently latched in the DUT
    logic [15:0] m_ir, m_ig, m_ib;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] inv_of(input logic [7:0] a);
        int unsigned q;
        if (a == 8'd0) return 16'hFFFF;
        q = 65536 / a;
        return (q > 65535) ? 16'hFFFF : 16'(q);
    endfunction

    // Reference transmission straight from the defining equations
    function automatic logic [7:0] ref_t(input logic [23:0] p, input logic [15:0] ir,
                                         input logic [15:0] ig, input logic [15:0] ib);
        int unsigned n[3];
        int unsigned m, k, t;
        n[0] = (int'(p[23:16]) * int'(ir)) / 256;
        n[1] = (int'(p[15:8])  * int'(ig)) / 256;
        n[2] = (int'(p[7:0])   * int'(ib)) / 256;
        for (int i = 0; i < 3; i++) if (n[i] > 255) n[i] = 255;
        m = n[0];
        if (n[1] < m) m = n[1];
        if (n[2] < m) m = n[2];
        k = (243 * m) / 256;
        t = 255 - k;
        if (t < 26) t = 26;
        return 8'(t);
    endfunction

    // Output monitor: pop and compare every produced pixel
    always @(negedge clk) begin
        if (!rst && bus.output_is_valid) begin
            nvalid++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got pixel=%h t=%0d, required no output", bus.out_pixel, bus.out_t);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_pixel !== e.pix || bus.out_t !== e.t || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL sb_output: got pixel=%h t=%0d cyc=%0d, required pixel=%h t=%0d cyc=%0d",
                             bus.out_pixel, bus.out_t, cyc, e.pix, e.t, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ale_valid = 1'b0;
        bus.input_is_valid = 1'b0;
        bus.input_pixel = '0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        nvalid = 0;
    endtask

    task automatic set_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.a_r = r;  bus.a_g = g;  bus.a_b = b;
        bus.inv_a_r = inv_of(r);
        bus.inv_a_g = inv_of(g);
        bus.inv_a_b = inv_of(b);
    endtask

    task automatic send_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        set_a(r, g, b);
        bus.ale_valid = 1'b1;
        step();
        bus.ale_valid = 1'b0;
        m_ir = inv_of(r);  m_ig = inv_of(g);  m_ib = inv_of(b);
    endtask

    task automatic send_pix(input logic [23:0] p, input bit expect_out);
        exp_t e;
        bus.input_pixel = p;
        bus.input_is_valid = 1'b1;
        if (expect_out) begin
            e.pix = p;
            e.t   = ref_t(p, m_ir, m_ig, m_ib);
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
        step();
        bus.input_is_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic check_t(input string name, input logic [7:0] exp_val, input logic [23:0] exp_pix);
        total++;
        if (bus.out_t !== exp_val || bus.out_pixel !== exp_pix) begin
            bad++;
            $display("FAIL %s: got t=%0d pixel=%h, required t=%0d pixel=%h", name, bus.out_t, bus.out_pixel, exp_val, exp_pix);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.out_pixel, bus.out_t, bus.out_a, bus.output_is_valid, bus.busy, bus.drop_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got pix=%h t=%0d a=%h v=%b busy=%b drop=%b, required all 0",
                     bus.out_pixel, bus.out_t, bus.out_a, bus.output_is_valid, bus.busy, bus.drop_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_a(8'd200, 8'd200, 8'd200);
        send_pix(24'h646464, 1'b1);
        wait_drain();
        check_t("basic_t135", 8'd135, 24'h646464);
        do_reset();
        send_a(8'd255, 8'd255, 8'd255);
        send_pix(24'hFFFFFF, 1'b1);
        wait_drain();
        check_t("clamp_tmin", 8'd26, 24'hFFFFFF);
        do_reset();
        send_a(8'd50, 8'd50, 8'd50);
        send_pix({8'd200, 8'd10, 8'd200}, 1'b1);
        wait_drain();
        check_t("sat_min_t207", 8'd207, {8'd200, 8'd10, 8'd200});
    endtask

    task automatic test_zero();
        do_reset();
        send_a(8'd0, 8'd0, 8'd0);
        send_pix(24'h000100, 1'b1);
        wait_drain();
        check_t("zero_pixel_t255", 8'd255, 24'h000100);
        send_pix(24'h010101, 1'b1);
        wait_drain();
        check_t("zero_a_sat", 8'd26, 24'h010101);
    endtask

    task automatic test_frame_end();
        do_reset();
        send_a(8'd200, 8'd180, 8'd160);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_before_last: got %b, required 1", bus.busy);
                end
            end
            send_pix(24'(32'h102030 * (i + 1)), 1'b1);
            if (i == 3) begin
                total++;
                if (bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_last: got %b, required 0", bus.busy);
                end
            end
            repeat (i) step();
        end
        total++;
        if (bus.drop_err !== 1'b0) begin
            bad++;
            $display("FAIL drop_before: got %b, required 0", bus.drop_err);
        end
        send_pix(24'h777777, 1'b0);
        wait_drain();
        repeat (4) step();
        total++;
        if (nvalid !== 4) begin
            bad++;
            $display("FAIL frame_count: got %0d outputs, required 4", nvalid);
        end
        total++;
        if (bus.drop_err !== 1'b1) begin
            bad++;
            $display("FAIL drop_set: got %b, required 1", bus.drop_err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        send_a(8'd200, 8'd200, 8'd200);
        for (int i = 0; i < 3; i++) send_pix(24'($urandom), 1'b1);
        // Last pixel of frame with a new A on the same cycle
        set_a(8'd100, 8'd100, 8'd100);
        bus.ale_valid = 1'b1;
        bus.input_pixel = {8'd50, 8'd60, 8'd70};
        bus.input_is_valid = 1'b1;
        e.pix = {8'd50, 8'd60, 8'd70};
        e.t   = ref_t(e.pix, m_ir, m_ig, m_ib);
        e.cyc = cyc + 4;
        sb.push_back(e);
        step();
        bus.ale_valid = 1'b0;
        bus.input_is_valid = 1'b0;
        m_ir = inv_of(8'd100);  m_ig = inv_of(8'd100);  m_ib = inv_of(8'd100);
        total++;
        if (bus.busy !== 1'b1 || bus.out_a !== 24'h646464) begin
            bad++;
            $display("FAIL chain_a: got busy=%b a=%h, required busy=1 a=646464", bus.busy, bus.out_a);
        end
        send_pix({8'd50, 8'd60, 8'd70}, 1'b1);
        wait_drain();
        check_t("new_a_t135", 8'd135, {8'd50, 8'd60, 8'd70});
    endtask

    task automatic test_reset_midflight();
        do_reset();
        send_a(8'd200, 8'd200, 8'd200);
        send_pix(24'h646464, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({bus.out_pixel, bus.out_t, bus.out_a, bus.output_is_valid, bus.busy, bus.drop_err} !== '0) begin
                bad++;
                $display("FAIL midreset_outputs: got pix=%h t=%0d a=%h v=%b busy=%b, required all 0",
                         bus.out_pixel, bus.out_t, bus.out_a, bus.output_is_valid, bus.busy);
            end
            step();
        end
        send_pix(24'h010203, 1'b0);
        total++;
        if (bus.drop_err !== 1'b1) begin
            bad++;
            $display("FAIL midreset_idle: got drop=%b, required 1", bus.drop_err);
        end
        repeat (6) step();
    endtask

    initial begin
        rst = 1'b1;
        set_a(8'd0, 8'd0, 8'd0);
        bus.ale_valid = 1'b0;
        bus.input_pixel = '0;
        bus.input_is_valid = 1'b0;
        m_ir = '0;  m_ig = '0;  m_ib = '0;
        test_reset();
        test_basic();
        test_zero();
        test_frame_end();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
